// File: rtl/wb_arbiter.sv
// Two-requester round-robin writeback arbiter feeding a single register-file write port.
// Define WB_ARBITER_SCOREBOARD_EN to add a 32-entry busy-bit scoreboard for source-operand hazard checks.
module wb_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [4:0]  exu_rd,
    input  logic [63:0] exu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [63:0] lsu_data,
    output logic        rf_wen,
    output logic [4:0]  rf_rdAddr,
    output logic [63:0] rf_rdData,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1Addr,
    input  logic [4:0]  rs2Addr,
    output logic        rs1_busy,
    output logic        rs2_busy
);

    typedef enum logic {
        LAST_EXU = 1'b0,
        LAST_LSU = 1'b1
    } winner_t;

    winner_t     last_q;
    winner_t     last_d;
    logic        grant_exu;
    logic        grant_lsu;
    logic        grant;
    logic [4:0]  win_rd;
    logic [63:0] win_data;

    // Readies are held low during reset so nothing can be granted in that cycle.
    always_comb begin
        grant_exu = 1'b0;
        grant_lsu = 1'b0;
        last_d    = last_q;
        if (!reset) begin
            if (exu_valid && lsu_valid) begin
                if (last_q == LAST_LSU) begin
                    grant_exu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else if (exu_valid) begin
                grant_exu = 1'b1;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
        if (grant_exu) begin
            last_d = LAST_EXU;
        end else if (grant_lsu) begin
            last_d = LAST_LSU;
        end
    end

    assign exu_ready = grant_exu;
    assign lsu_ready = grant_lsu;
    assign grant     = grant_exu | grant_lsu;
    assign win_rd    = grant_exu ? exu_rd   : lsu_rd;
    assign win_data  = grant_exu ? exu_data : lsu_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q    <= LAST_LSU;
            rf_wen    <= 1'b0;
            rf_rdAddr <= '0;
            rf_rdData <= '0;
        end else begin
            last_q <= last_d;
            rf_wen <= grant && (win_rd != 5'd0);
            if (grant) begin
                rf_rdAddr <= win_rd;
                rf_rdData <= win_data;
            end
        end
    end

`ifdef WB_ARBITER_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Clear is applied before set so an issue to the retiring register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen) begin
            busy_d[rf_rdAddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = (rs1Addr != 5'd0) && busy_q[rs1Addr];
    assign rs2_busy = (rs2Addr != 5'd0) && busy_q[rs2Addr];
`else
    logic unused_sb;
    assign unused_sb = ^{iss_valid, iss_rd, rs1Addr, rs2Addr};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a cycle-level reference model checked every cycle plus literal spot checks.
// Scoreboard scenarios run when WB_ARBITER_SCOREBOARD_EN is defined; otherwise busy outputs must stay 0.
module tb_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        exu_valid, lsu_valid;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd;
    logic [63:0] exu_data, lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_rdAddr;
    logic [63:0] rf_rdData;
    logic        iss_valid;
    logic [4:0]  iss_rd, rs1Addr, rs2Addr;
    logic        rs1_busy, rs2_busy;

    int total = 0;
    int bad   = 0;

    wb_arbiter dut (
        .clock(clock), .reset(reset),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_rdAddr(rf_rdAddr), .rf_rdData(rf_rdData),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who won last, what the write port should show, which registers are pending.
    logic        armed = 1'b0;
    logic        m_last_lsu;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    bit          m_busy [32];

    // Returns 1 if exu is granted, 2 if lsu is granted, 0 if nobody is.
    function automatic int winner();
        if (reset) return 0;
        if (exu_valid && lsu_valid) return m_last_lsu ? 1 : 2;
        if (exu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx);
`ifdef WB_ARBITER_SCOREBOARD_EN
        return (idx != 0) && m_busy[idx];
`else
        return 1'b0;
`endif
    endfunction

    always begin
        int w;
        @(negedge clock);
        if (armed) begin
            w = winner();
            check("exu_ready", exu_ready, (w == 1));
            check("lsu_ready", lsu_ready, (w == 2));
            check("rf_wen", rf_wen, m_wen);
            check("rf_rdAddr", rf_rdAddr, m_addr);
            check("rf_rdData", rf_rdData, m_data);
            check("rs1_busy", rs1_busy, exp_busy(rs1Addr));
            check("rs2_busy", rs2_busy, exp_busy(rs2Addr));
        end
        @(posedge clock);
        w = winner();
        if (reset) begin
            armed      = 1'b1;
            m_last_lsu = 1'b1;
            m_wen      = 1'b0;
            m_addr     = '0;
            m_data     = '0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (m_wen) m_busy[m_addr] = 0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
            m_wen = 1'b0;
            if (w != 0) begin
                m_last_lsu = (w == 2);
                m_addr     = (w == 1) ? exu_rd   : lsu_rd;
                m_data     = (w == 1) ? exu_data : lsu_data;
                m_wen      = (m_addr != 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pattern;
        pattern = 4'b0101;
        reset = 1'b1;
        exu_valid = 0; lsu_valid = 0; exu_rd = 0; lsu_rd = 0; exu_data = 0; lsu_data = 0;
        iss_valid = 0; iss_rd = 0; rs1Addr = 0; rs2Addr = 0;
        tick();
        @(negedge clock);
        check("lit_reset_wen", rf_wen, 0);
        check("lit_reset_data", rf_rdData, 0);
        tick();
        reset = 1'b0;

        // Contention straight out of reset: exu, lsu, exu, lsu.
        exu_valid = 1; exu_rd = 1; exu_data = 64'h11;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("lit_rr_exu_ready", exu_ready, pattern[i]);
            if (i > 0) begin
                check("lit_rr_wen", rf_wen, 1);
                check("lit_rr_addr", rf_rdAddr, (i % 2 == 1) ? 1 : 2);
            end
            tick();
        end
        exu_valid = 0; lsu_valid = 0;
        @(negedge clock);
        check("lit_rr_wen_last", rf_wen, 1);
        check("lit_rr_addr_last", rf_rdAddr, 2);
        tick();

        // Single exu request.
        exu_valid = 1; exu_rd = 5; exu_data = 64'hAB;
        @(negedge clock);
        check("lit_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 0;
        @(negedge clock);
        check("lit_exu_wen", rf_wen, 1);
        check("lit_exu_addr", rf_rdAddr, 5);
        check("lit_exu_data", rf_rdData, 64'hAB);
        tick();

        // lsu write to x0: accepted but no register-file write.
        lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hFF;
        @(negedge clock);
        check("lit_x0_ready", lsu_ready, 1);
        tick();
        lsu_valid = 0;
        @(negedge clock);
        check("lit_x0_wen", rf_wen, 0);
        tick();
        tick();

        // Uncontended exu grant moves the pointer, so the next contention goes to lsu.
        exu_valid = 1; exu_rd = 9; exu_data = 64'h9999;
        tick();
        lsu_valid = 1; lsu_rd = 10; lsu_data = 64'hAAAA;
        @(negedge clock);
        check("lit_ptr_lsu_ready", lsu_ready, 1);
        tick();
        exu_valid = 0; lsu_valid = 0;
        tick();

`ifdef WB_ARBITER_SCOREBOARD_EN
        iss_valid = 1; iss_rd = 7; rs1Addr = 7;
        @(negedge clock);
        check("lit_sb_not_yet", rs1_busy, 0);
        tick();
        iss_valid = 0;
        @(negedge clock);
        check("lit_sb_set", rs1_busy, 1);
        exu_valid = 1; exu_rd = 7; exu_data = 64'h77;
        tick();
        exu_valid = 0;
        @(negedge clock);
        check("lit_sb_wen7", rf_wen, 1);
        check("lit_sb_still", rs1_busy, 1);
        tick();
        @(negedge clock);
        check("lit_sb_cleared", rs1_busy, 0);
        tick();

        exu_valid = 1; exu_rd = 3; exu_data = 64'h33; rs2Addr = 3;
        tick();
        exu_valid = 0; iss_valid = 1; iss_rd = 3;
        @(negedge clock);
        check("lit_sb_wen3", rf_wen, 1);
        tick();
        iss_valid = 0;
        @(negedge clock);
        check("lit_sb_set_wins", rs2_busy, 1);
        rs2Addr = 0; iss_valid = 1; iss_rd = 0;
        tick();
        iss_valid = 0;
        @(negedge clock);
        check("lit_sb_x0", rs2_busy, 0);
        rs2Addr = 3;
        tick();
`else
        iss_valid = 1; iss_rd = 7; rs1Addr = 7; rs2Addr = 7;
        tick();
        iss_valid = 0;
        @(negedge clock);
        check("lit_nosb_rs1", rs1_busy, 0);
        check("lit_nosb_rs2", rs2_busy, 0);
        tick();
`endif

        // exu wins last, then reset arrives while both request.
        exu_valid = 1; exu_rd = 12; exu_data = 64'hC;
        tick();
        lsu_valid = 1; lsu_rd = 13; lsu_data = 64'hD; exu_rd = 4; exu_data = 64'h44;
        reset = 1;
        @(negedge clock);
        check("lit_rst_exu_ready", exu_ready, 0);
        check("lit_rst_lsu_ready", lsu_ready, 0);
        tick();
        reset = 0;
        @(negedge clock);
        check("lit_rst_wen", rf_wen, 0);
        check("lit_rst_busy", rs2_busy, 0);
        check("lit_rst_exu_wins", exu_ready, 1);
        tick();
        exu_valid = 0; lsu_valid = 0;
        @(negedge clock);
        check("lit_rst_write", rf_rdAddr, 4);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- exu_valid  in  1  execute-unit writeback request.
- exu_ready  out  1  execute-unit request granted this cycle.
- exu_rd  in  5  execute-unit destination register.
- exu_data  in  64  execute-unit result.
- lsu_valid  in  1  load/store-unit writeback request.
- lsu_ready  out  1  load/store-unit request granted this cycle.
- lsu_rd  in  5  load/store-unit destination register.
- lsu_data  in  64  load data.
- rf_wen  out  1  register-file write enable.
- rf_rdAddr  out  5  register-file write address.
- rf_rdData  out  64  register-file write data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  5  destination register of the issuing instruction.
- rs1Addr  in  5  source-1 register index to check.
- rs2Addr  in  5  source-2 register index to check.
- rs1_busy  out  1  source-1 register has a write pending.
- rs2_busy  out  1  source-2 register has a write pending.

Function
REQ-002 The block SHALL drive exu_ready and lsu_ready combinationally from the valids and the round-robin pointer, and SHALL never assert both in the same cycle.
REQ-003 With exactly one valid asserted, the block SHALL assert the matching ready.
REQ-004 With both valids asserted, the block SHALL grant the requester that did not win the most recent grant.
REQ-005 A 1-bit pointer SHALL record the last winner and SHALL update on every grant, whether or not the two requesters contended.
REQ-006 A grant SHALL mean valid&ready; it SHALL register rd and data into rf_rdAddr/rf_rdData and assert rf_wen for exactly the following cycle (1-cycle latency).
REQ-007 With no grant in a cycle, rf_wen SHALL be 0 the next cycle, and rf_rdAddr/rf_rdData SHALL hold their last values.
REQ-008 A granted request with rd==0 SHALL be accepted (ready=1) but SHALL leave rf_wen=0 the next cycle.
REQ-009 The arbiter SHALL sustain one write per cycle with back-to-back grants and no bubbles.
REQ-010 A requester SHALL hold valid, rd and data stable until granted; the arbiter SHALL neither store nor queue ungranted requests.

Reset
REQ-011 While reset is asserted, rf_wen, rf_rdAddr and rf_rdData SHALL be 0, the pointer SHALL indicate lsu (so exu wins the first contention), all busy bits SHALL be 0, and both readies SHALL be 0.
REQ-012 A write registered in the cycle reset is asserted SHALL be discarded, and rf_wen SHALL be 0 in the following cycle.

Configuration
REQ-013 Macro WB_ARBITER_SCOREBOARD_EN SHALL compile in a 32-entry busy-bit scoreboard.
REQ-014 With the macro defined, iss_valid with iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-015 With the macro defined, a cycle with rf_wen=1 SHALL clear busy[rf_rdAddr] at the next edge.
REQ-016 With the macro defined, when a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-017 With the macro defined, rs1_busy/rs2_busy SHALL be combinational busy[rs1Addr]/busy[rs2Addr], forced to 0 for index 0.
REQ-018 Without the macro, rs1_busy and rs2_busy SHALL be tied 0, iss_valid and iss_rd SHALL be ignored, and no scoreboard storage SHALL exist.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- exu_valid=1, exu_rd=5, exu_data=0xAB, lsu_valid=0 -> exu_ready=1 same cycle; next cycle rf_wen=1, rf_rdAddr=5, rf_rdData=0xAB.
- Both valid held 4 cycles after reset (exu_rd=1, lsu_rd=2) -> grants exu, lsu, exu, lsu; rf_wen=1 for 4 consecutive cycles.
- lsu_valid=1, lsu_rd=0, lsu_data=0xFF -> lsu_ready=1; next cycle rf_wen=0.
- Macro on: iss_valid=1, iss_rd=7; rs1Addr=7 -> rs1_busy=1 from the next cycle; exu write to rd=7 -> rs1_busy=0 the cycle after rf_wen.
- Macro on: same cycle iss_rd=3 and rf_wen=1 with rf_rdAddr=3 -> busy[3] remains 1; rs2Addr=0 -> rs2_busy=0 always.
- Grant in cycle N with reset asserted in cycle N -> rf_wen=0 in cycle N+1; all busy=0; the next contention is won by exu.
